// File: rtl/jogo_memoria_param_if.sv
// rtl/jogo_memoria_param_if.sv - Player/board-side signal bundle for the memory game engine
interface jogo_memoria_param_if #(parameter int N_BOTOES = 4) ();
    logic                jogar;
    logic [N_BOTOES-1:0] botoes;
    logic [N_BOTOES-1:0] leds;
    logic                pronto;
    logic                ganhou;
    logic                perdeu;
    logic [3:0]          db_estado;
    logic [7:0]          db_rodada;
    logic                db_timeout;

    modport master (
        output jogar, botoes,
        input  leds, pronto, ganhou, perdeu, db_estado, db_rodada, db_timeout
    );

    modport slave (
        input  jogar, botoes,
        output leds, pronto, ganhou, perdeu, db_estado, db_rodada, db_timeout
    );
endinterface

// File: rtl/jogo_memoria_param.sv
// rtl/jogo_memoria_param.sv - LFSR-driven memory-sequence game engine
// Optional press timeout is built only when JOGO_TIMEOUT_EN is defined.
module jogo_memoria_param #(
    parameter int          N_BOTOES       = 4,
    parameter int          PROF           = 16,
    parameter int          TEMPO_LED      = 1000,
    parameter int          TIMEOUT_CICLOS = 5000,
    parameter logic [15:0] SEMENTE        = 16'hACE1
) (
    input  logic               clock,
    input  logic               reset,
    jogo_memoria_param_if.slave bus
);
    localparam int LW = $clog2(N_BOTOES);
    localparam int TW = $clog2(TEMPO_LED + 1);
    localparam logic [N_BOTOES-1:0] ALVO_SEMENTE = N_BOTOES'(1) << SEMENTE[LW-1:0];

    typedef enum logic [3:0] {
        INICIAL    = 4'd0,
        PREPARA    = 4'd1,
        CARREGA_M  = 4'd2,
        MOSTRA     = 4'd3,
        APAGA      = 4'd4,
        CARREGA_J  = 4'd5,
        ESPERA     = 4'd6,
        COMPARA    = 4'd7,
        SOLTA      = 4'd8,
        FIM_RODADA = 4'd9,
        ACERTOU    = 4'd10,
        ERROU      = 4'd11
    } estado_t;

    estado_t             estado;
    logic [15:0]         lfsr;
    logic [15:0]         lfsr_step;
    logic [7:0]          idx;
    logic [7:0]          rodada;
    logic [TW-1:0]       tmr;
    logic                tmr_fim;
    logic [N_BOTOES-1:0] btn_reg;
    logic [N_BOTOES-1:0] leds;
    logic [N_BOTOES-1:0] alvo;
    logic [N_BOTOES-1:0] alvo_step;
    logic                pronto, ganhou, perdeu;
    logic                any_btn, any_prev, press;
    logic                to_fim;

    assign lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign alvo      = N_BOTOES'(1) << lfsr[LW-1:0];
    assign alvo_step = N_BOTOES'(1) << lfsr_step[LW-1:0];
    assign tmr_fim   = (tmr == TW'(TEMPO_LED - 1));
    assign any_btn   = |bus.botoes;
    // A press is the all-released to any-held transition, so a held button never re-triggers
    assign press     = any_btn & ~any_prev;

`ifdef JOGO_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CICLOS);
    logic [CW-1:0] to_cnt;
    logic          timeout_flag;

    assign to_fim = (to_cnt == CW'(TIMEOUT_CICLOS - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else begin
            to_cnt <= (estado == ESPERA) ? to_cnt + 1'b1 : '0;
            if (estado == PREPARA)
                timeout_flag <= 1'b0;
            else if (estado == ESPERA && !press && to_fim)
                timeout_flag <= 1'b1;
        end
    end

    assign bus.db_timeout = timeout_flag;
`else
    assign to_fim         = 1'b0;
    assign bus.db_timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= INICIAL;
            lfsr     <= SEMENTE;
            idx      <= '0;
            rodada   <= '0;
            tmr      <= '0;
            btn_reg  <= '0;
            leds     <= '0;
            pronto   <= 1'b0;
            ganhou   <= 1'b0;
            perdeu   <= 1'b0;
            any_prev <= 1'b0;
        end else begin
            any_prev <= any_btn;
            case (estado)
                INICIAL: if (bus.jogar) estado <= PREPARA;
                PREPARA: begin
                    rodada <= 8'd1;
                    pronto <= 1'b0;
                    ganhou <= 1'b0;
                    perdeu <= 1'b0;
                    estado <= CARREGA_M;
                end
                CARREGA_M: begin
                    lfsr   <= SEMENTE;
                    idx    <= '0;
                    tmr    <= '0;
                    leds   <= ALVO_SEMENTE;
                    estado <= MOSTRA;
                end
                MOSTRA: begin
                    if (tmr_fim) begin
                        tmr    <= '0;
                        leds   <= '0;
                        estado <= APAGA;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                APAGA: begin
                    if (tmr_fim) begin
                        tmr  <= '0;
                        lfsr <= lfsr_step;
                        idx  <= idx + 8'd1;
                        if (idx + 8'd1 == rodada) begin
                            estado <= CARREGA_J;
                        end else begin
                            leds   <= alvo_step;
                            estado <= MOSTRA;
                        end
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                CARREGA_J: begin
                    lfsr   <= SEMENTE;
                    idx    <= '0;
                    estado <= ESPERA;
                end
                ESPERA: begin
                    if (press) begin
                        btn_reg <= bus.botoes;
                        estado  <= COMPARA;
                    end else if (to_fim) begin
                        perdeu <= 1'b1;
                        pronto <= 1'b1;
                        estado <= ERROU;
                    end
                end
                COMPARA: begin
                    // Exact one-hot match: chords with extra bits are wrong answers
                    if (btn_reg != alvo) begin
                        perdeu <= 1'b1;
                        pronto <= 1'b1;
                        estado <= ERROU;
                    end else if (idx + 8'd1 == rodada) begin
                        estado <= FIM_RODADA;
                    end else begin
                        lfsr   <= lfsr_step;
                        idx    <= idx + 8'd1;
                        estado <= SOLTA;
                    end
                end
                SOLTA: if (!any_btn) estado <= ESPERA;
                FIM_RODADA: begin
                    if (rodada == 8'(PROF)) begin
                        ganhou <= 1'b1;
                        pronto <= 1'b1;
                        estado <= ACERTOU;
                    end else if (!any_btn) begin
                        rodada <= rodada + 8'd1;
                        estado <= CARREGA_M;
                    end
                end
                ACERTOU, ERROU: if (bus.jogar) estado <= PREPARA;
                default: estado <= INICIAL;
            endcase
        end
    end

    assign bus.leds      = leds;
    assign bus.pronto    = pronto;
    assign bus.ganhou    = ganhou;
    assign bus.perdeu    = perdeu;
    assign bus.db_estado = estado;
    assign bus.db_rodada = rodada;
endmodule

// File: doc/jogo_memoria_param.md
# jogo_memoria_param

Parametrised, self-contained memory-sequence game engine ("Genius"), successor to the fixed 4-button, ROM-based game. It generates the target sequence on the fly from a seeded LFSR, so no sequence memory is needed. Each round it plays the sequence back on the LEDs, then checks player button presses against it. Round length grows by one per round up to `PROF`. It sits directly under the board top level; seven-segment decoding stays outside.

## Interface
- `N_BOTOES`, 4: number of buttons/LEDs; legal values 2, 4, 8.
- `PROF`, 16: rounds to win (max sequence length), 1..255.
- `TEMPO_LED`, 1000: cycles each element is shown, and cycles of the dark gap after it; ≥1.
- `TIMEOUT_CICLOS`, 5000: cycles allowed per press; ≥2.
- `SEMENTE`, 16'hACE1: LFSR seed; must be nonzero.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `jogar` in 1: start/restart request, level-sampled.
- `botoes` in N_BOTOES: player buttons, active-high, synchronous to `clock`.
- `leds` out N_BOTOES: one-hot playback display.
- `pronto` out 1: game over.
- `ganhou` out 1: game won.
- `perdeu` out 1: game lost.
- `db_estado` out 4: FSM state code.
- `db_rodada` out 8: current round (1-based).
- `db_timeout` out 1: loss was caused by timeout.

## Operation
- **LFSR:** 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, shifting left, feedback into bit 0. It is reloaded with `SEMENTE` at the start of every playback and every input phase.
  - Element value = `lfsr[log2(N_BOTOES)-1:0]`, taken before the step.
  - The LFSR steps once per element consumed.
  - Element k is therefore identical in every round.
- **Element counter `idx`:** 8 bits. **Round counter `rodada`:** 8 bits.
- **FSM states (code):**
  - INICIAL(0): all outputs 0. `jogar`=1 → PREPARA.
  - PREPARA(1): `rodada`←1, clear flags → CARREGA_M.
  - CARREGA_M(2): load seed, `idx`←0 → MOSTRA.
  - MOSTRA(3): `leds` = one-hot(element) for `TEMPO_LED` cycles → APAGA.
  - APAGA(4): `leds`=0 for `TEMPO_LED` cycles; step LFSR; `idx`++. If `idx`+1 = `rodada` → CARREGA_J, else → MOSTRA.
  - CARREGA_J(5): load seed, `idx`←0, zero the timeout counter → ESPERA.
  - ESPERA(6): wait for a press (a rising edge of "any button", from all-zero to nonzero); register `botoes` → COMPARA.
  - COMPARA(7):
    - Registered value must equal one-hot(element); more than one bit set counts as wrong.
    - Wrong → ERROU.
    - Right and `idx`+1 < `rodada` → SOLTA.
    - Right and `idx`+1 = `rodada` → FIM_RODADA.
  - SOLTA(8): step LFSR, `idx`++, zero the timeout counter; wait for all buttons released → ESPERA.
  - FIM_RODADA(9): if `rodada` = `PROF` → ACERTOU; else `rodada`++, wait for release → CARREGA_M.
  - ACERTOU(10): `ganhou`=1, `pronto`=1. `jogar`=1 → PREPARA.
  - ERROU(11): `perdeu`=1, `pronto`=1. `jogar`=1 → PREPARA.
- **Held outputs:** `ganhou`, `perdeu` and `db_timeout` are held until the next PREPARA.
- **Ignored input:** `jogar` is ignored in all states other than INICIAL, ACERTOU and ERROU.
- **Held button at phase entry:** a button already held on entry to ESPERA is not a press; a release is required first.

## Timing
- **Reset:** asserting `reset` (low) puts the FSM in INICIAL asynchronously. All outputs, counters and the button register go to 0; the LFSR goes to `SEMENTE`. Reset mid-round abandons the game.
- **Output registration:** all outputs are registered and decoded from state and registers.
- **Start:** `jogar` sampled high in INICIAL → first LED lit 3 cycles later (PREPARA, CARREGA_M, MOSTRA).
- **Round playback:** takes `rodada`·2·`TEMPO_LED` cycles.
- **Press recognition:** the press is registered on the clock edge where the edge is detected. The verdict appears one cycle later (COMPARA).
- **Timeout:** the timeout counter runs only in ESPERA and is zeroed on CARREGA_J and SOLTA. When it reaches `TIMEOUT_CICLOS`-1 with no press, the FSM goes to ERROU and `db_timeout`←1. A press on the same cycle as the timeout wins over the timeout.

## Configuration
- **Macro `JOGO_TIMEOUT_EN`:** when defined, the timeout counter and `db_timeout` behave as above.
- **Without the macro:** the counter is not built, ESPERA waits indefinitely, and `db_timeout` is tied to 0.

## Test plan
All scenarios use `N_BOTOES`=4, `PROF`=3, `TEMPO_LED`=2, `TIMEOUT_CICLOS`=20, `SEMENTE`=16'hACE1, with `JOGO_TIMEOUT_EN` defined unless noted.
- **Reset state:** drop `reset` mid-MOSTRA → `leds`=0, `db_estado`=0, `pronto`=0 immediately, without waiting for a clock edge.
- **Round 1 playback:** pulse `jogar` → `leds`=4'b0010 for exactly 2 cycles, then 0 for 2 cycles. `db_rodada`=1.
- **Full win:** press each element as played, releasing between presses, for rounds 1–3 → `ganhou`=1, `pronto`=1, `perdeu`=0, `db_estado`=10.
- **Wrong input:** in round 1, press 4'b0011 → `perdeu`=1, `db_timeout`=0, `db_estado`=11, two cycles after the press edge.
- **Timeout:** give no press in ESPERA → ERROU after 20 cycles, `db_timeout`=1. With `JOGO_TIMEOUT_EN` undefined, the FSM is still in ESPERA after 1000 cycles.
- **Restart and held button:** from ERROU, pulse `jogar` → round 1 replays identically with flags cleared. Holding a button through CARREGA_J does not register a press.
